kp_unloader: RTL and testbench
==============================

# kp_unloader

Output serializer directly downstream of the ECC point-multiply engine. It captures a finished 32-bit result point (x, y) and streams it out as 16 4-bit nibbles on `kP`, each qualified by `ready`. The nibble format mirrors the 8-cycle MSB-first input load format. A one-entry pending buffer absorbs a result that arrives while a frame is streaming. An optional consumer `hold` pauses the stream.

## Interface
- `WORD_W`, 32, coordinate width in bits.
- `NIB_W`, 4, nibble width. `WORD_W` must be a multiple of `NIB_W`. Nibbles per coordinate: `NPC = WORD_W/NIB_W` = 8.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `res_valid`  in  1  one-cycle pulse; `res_x`/`res_y` are valid in that cycle.
- `res_x`  in  WORD_W  result x coordinate.
- `res_y`  in  WORD_W  result y coordinate.
- `hold`  in  1  consumer stall request.
- `ready`  out  1  `kP` carries a valid nibble this cycle.
- `kP`  out  NIB_W  output nibble.
- `busy`  out  1  a frame is in progress or the pending buffer is full.
- `ovf`  out  1  sticky flag: a result was dropped.

## Operation
- States:
  - IDLE: waiting for a result.
  - SEND_X: streaming the x nibbles.
  - SEND_Y: streaming the y nibbles.
  - GAP: one-cycle frame separator.
- Datapath:
  - Active frame register: x and y, 2×WORD_W.
  - Pending buffer: x, y and a valid bit.
  - Nibble index counter: 0..NPC-1.
- IDLE, `res_valid`=1: load the active register and go to SEND_X with index 0.
- Nibble emission (SEND_X/SEND_Y, `hold`=0):
  - `kP` gets the nibble at position `index` counting from the MSB, i.e. `coord[WORD_W-1-NIB_W*index -: NIB_W]`.
  - `ready`=1 and the index increments.
  - When the index reaches NPC-1 it wraps to 0 and the state moves SEND_X→SEND_Y, or SEND_Y→GAP.
- Hold (SEND_X/SEND_Y, `hold`=1): `ready`=0 the next cycle, `kP` holds its value, index and state are unchanged. No nibble is skipped or repeated.
- GAP:
  - `ready`=0.
  - If the pending buffer is valid: move it into the active register, clear pending, go to SEND_X with index 0.
  - Otherwise go to IDLE.
- `res_valid` outside IDLE:
  - Pending empty: store the result in pending.
  - Pending full: drop the result and set `ovf`=1. `ovf` clears only on `rst`.
- Simultaneous pending unload (in GAP) and `res_valid`: the buffer is freed and reloaded with the new result in the same cycle. No overflow.
- `res_valid` in IDLE while pending is empty: goes straight to the active register.
- `busy` = (state ≠ IDLE) | pending valid.
- `hold` in IDLE or GAP has no effect.

## Timing
- All outputs are registered.
- Reset values:
  - `ready`=0, `kP`=0, `busy`=0, `ovf`=0.
  - State IDLE, pending valid 0, index 0.
- Latency: with `res_valid` in cycle t (IDLE) and no hold:
  - `ready`=1 in cycles t+1..t+16.
  - x[31:28] at t+1 through x[3:0] at t+8.
  - y[31:28] at t+9 through y[3:0] at t+16.
  - `ready`=0 at t+17 (GAP).
- Back-to-back results: if a pending result exists, its first nibble appears at t+18. Frames are always separated by exactly one `ready`=0 cycle.
- Each `hold`=1 cycle during SEND extends the frame by one cycle.
- `busy` rises in cycle t+1 and falls the cycle after GAP when nothing is pending.
- `rst` mid-frame aborts immediately: all registers return to reset values, the pending result is discarded, and the first edge after release is in IDLE.

## Test plan
- Reset then single result, x=0x12345678, y=0x9ABCDEF0, `hold`=0 → `kP` sequence 1,2,…,8,9,A,…,F,0 on 16 consecutive `ready` cycles starting 1 cycle after `res_valid`; then `ready`=0; `busy` falls; `ovf`=0.
- Hold: same result with `hold`=1 on cycles 3 and 10 of the stream → 18 cycles span the frame, 16 `ready` pulses, nibble order unchanged, `kP` stable during holds.
- Back-to-back: second result (x=0xFFFFFFFF, y=0) pulsed at stream cycle 5 → first frame completes, one GAP cycle, then F×8, 0×8; `ovf`=0.
- Overflow: three results A, B, C within one frame → frames A and B streamed, C dropped, `ovf`=1 and stays 1 until `rst`.
- Boundary: `res_valid` in the GAP cycle with pending full → pending frame starts and the new result takes the buffer; three frames total, `ovf`=0.
- Reset mid-frame at nibble 6 → `ready`=0, `kP`=0, `busy`=0 immediately; a following result streams correctly from x[31:28].

Source files
------------

// File: rtl/kp_unloader.sv
// kp_unloader
//   Serializes a finished point-multiply result (x, y) into 2*WORD_W/NIB_W
//   nibbles, MSB first: all x nibbles, then all y nibbles, then one idle
//   separator cycle. A one-entry pending buffer catches a result that arrives
//   while a frame is in flight. A second result during that time is dropped
//   and flagged on the sticky ovf output.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   res_valid  one-cycle strobe, res_x/res_y valid with it
//   res_x      result x coordinate
//   res_y      result y coordinate
//   hold       consumer stall; pauses the stream while a frame is sending
//   ready      kP carries a valid nibble this cycle
//   kP         output nibble
//   busy       frame in progress or pending buffer occupied
//   ovf        sticky: a result was dropped
module kp_unloader #(
  parameter int WORD_W = 32,
  parameter int NIB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  input  logic [WORD_W-1:0] res_x,
  input  logic [WORD_W-1:0] res_y,
  input  logic              hold,
  output logic              ready,
  output logic [NIB_W-1:0]  kP,
  output logic              busy,
  output logic              ovf
);

  localparam int NPC   = WORD_W / NIB_W;
  localparam int IDX_W = (NPC > 1) ? $clog2(NPC) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NPC - 1);

  typedef enum logic [1:0] {IDLE, SEND_X, SEND_Y, GAP} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [WORD_W-1:0] act_x, act_y, pend_x, pend_y;
  logic              pend_vld, pend_vld_nxt;
  logic              load_act, load_from_pend, load_pend;
  logic              ready_nxt, ovf_nxt, busy_nxt;
  logic [NIB_W-1:0]  kp_nxt;

  // Nibble i of a coordinate, counted from the MSB.
  function automatic logic [NIB_W-1:0] nib_at(input logic [WORD_W-1:0] w,
                                              input logic [IDX_W-1:0]  i);
    logic [WORD_W-1:0] s;
    s = w << (NIB_W * int'(i));
    return s[WORD_W-1 -: NIB_W];
  endfunction

  // The output registers are loaded with the nibble that the *next* state
  // represents, so a frame's first nibble is visible in the cycle right after
  // the load and a state at index i is always showing nibble i.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    ready_nxt      = 1'b0;
    kp_nxt         = kP;
    ovf_nxt        = ovf;
    pend_vld_nxt   = pend_vld;
    load_act       = 1'b0;
    load_from_pend = 1'b0;
    load_pend      = 1'b0;

    case (state)
      IDLE, GAP: begin
        if (pend_vld) begin
          // Pending frame starts; a result arriving now refills the buffer.
          load_act       = 1'b1;
          load_from_pend = 1'b1;
          state_nxt      = SEND_X;
          idx_nxt        = '0;
          ready_nxt      = 1'b1;
          kp_nxt         = nib_at(pend_x, '0);
          pend_vld_nxt   = res_valid;
          load_pend      = res_valid;
        end else if (state == IDLE) begin
          if (res_valid) begin
            load_act  = 1'b1;
            state_nxt = SEND_X;
            idx_nxt   = '0;
            ready_nxt = 1'b1;
            kp_nxt    = nib_at(res_x, '0);
          end
        end else begin
          // GAP with nothing pending: a result here waits in the buffer.
          state_nxt    = IDLE;
          pend_vld_nxt = res_valid;
          load_pend    = res_valid;
        end
      end

      SEND_X, SEND_Y: begin
        if (!hold) begin
          if (idx == LAST) begin
            idx_nxt = '0;
            if (state == SEND_X) begin
              state_nxt = SEND_Y;
              ready_nxt = 1'b1;
              kp_nxt    = nib_at(act_y, '0);
            end else begin
              state_nxt = GAP;
            end
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            ready_nxt = 1'b1;
            kp_nxt    = nib_at((state == SEND_X) ? act_x : act_y, idx + IDX_W'(1));
          end
        end
        if (res_valid) begin
          if (pend_vld) begin
            ovf_nxt = 1'b1;
          end else begin
            pend_vld_nxt = 1'b1;
            load_pend    = 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE) | pend_vld_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      pend_vld <= 1'b0;
      ready    <= 1'b0;
      kP       <= '0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      pend_vld <= pend_vld_nxt;
      ready    <= ready_nxt;
      kP       <= kp_nxt;
      busy     <= busy_nxt;
      ovf      <= ovf_nxt;
    end
  end

  // Coordinate storage carries no reset; it is only read once loaded.
  always_ff @(posedge clk) begin
    if (load_act) begin
      act_x <= load_from_pend ? pend_x : res_x;
      act_y <= load_from_pend ? pend_y : res_y;
    end
    if (load_pend) begin
      pend_x <= res_x;
      pend_y <= res_y;
    end
  end

endmodule

// File: tb/tb_kp_unloader.sv
// Testbench for kp_unloader: directed scenarios followed by random traffic,
// every cycle checked against a frame-level reference model.
module tb_kp_unloader;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [31:0] res_x, res_y;
  logic        hold;
  logic        ready;
  logic [3:0]  kP;
  logic        busy;
  logic        ovf;

  kp_unloader #(.WORD_W(32), .NIB_W(4)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_x(res_x), .res_y(res_y),
    .hold(hold), .ready(ready), .kP(kP), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is one 64-bit word {x,y}; pos counts nibbles
  // already presented (1..16). gap marks the separator cycle.
  bit          m_act, m_gap, m_pv, m_ovf, m_rdy;
  int          m_pos;
  logic [63:0] m_cur, m_pend;
  logic [3:0]  m_kp;

  function automatic logic [3:0] nib(input logic [63:0] f, input int p);
    logic [63:0] s;
    s = f << (4 * p);
    return s[63:60];
  endfunction

  task automatic m_reset();
    m_act = 0; m_gap = 0; m_pv = 0; m_ovf = 0; m_rdy = 0; m_pos = 0; m_kp = 4'h0;
  endtask

  task automatic m_start(input logic [63:0] f);
    m_cur = f; m_act = 1; m_pos = 1; m_rdy = 1; m_kp = nib(f, 0);
  endtask

  task automatic m_edge(input bit rv, input logic [63:0] r, input bit h);
    if (m_act) begin
      if (h) m_rdy = 0;
      else if (m_pos == 16) begin m_act = 0; m_gap = 1; m_rdy = 0; end
      else begin m_kp = nib(m_cur, m_pos); m_pos++; m_rdy = 1; end
      if (rv) begin
        if (m_pv) m_ovf = 1;
        else begin m_pv = 1; m_pend = r; end
      end
    end else begin
      bit was_gap;
      was_gap = m_gap;
      m_gap = 0;
      if (m_pv) begin
        m_start(m_pend);
        m_pv = rv;
        if (rv) m_pend = r;
      end else if (!was_gap && rv) begin
        m_start(r);
      end else begin
        m_rdy = 0;
        if (was_gap && rv) begin m_pv = 1; m_pend = r; end
      end
    end
  endtask

  logic [3:0] got_q[$];
  int         got_cyc[$];
  int         cyc_no;

  // One clock: drive inputs, let the edge happen, compare at the falling edge.
  task automatic cyc(input bit rv, input logic [31:0] x, input logic [31:0] y, input bit h);
    res_valid = rv; res_x = x; res_y = y; hold = h;
    @(posedge clk);
    m_edge(rv, {x, y}, h);
    @(negedge clk);
    cyc_no++;
    chk("ready", 64'(ready), 64'(m_rdy));
    chk("kP", 64'(kP), 64'(m_kp));
    chk("busy", 64'(busy), 64'(m_act | m_gap | m_pv));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    if (ready) begin
      got_q.push_back(kP);
      got_cyc.push_back(cyc_no);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 32'h0, 32'h0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_reset();
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_kP", 64'(kP), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_scn();
    got_q.delete();
    got_cyc.delete();
    cyc_no = 0;
  endtask

  task automatic chk_frames(input string tag, input logic [63:0] f0, input logic [63:0] f1, input int nf);
    logic [63:0] fr;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(16 * nf));
    for (int i = 0; i < got_q.size() && i < 16 * nf; i++) begin
      fr = (i < 16) ? f0 : f1;
      chk({tag, "_nib"}, 64'(got_q[i]), 64'(nib(fr, i % 16)));
    end
  endtask

  initial begin
    rst = 1'b0; res_valid = 0; res_x = 0; res_y = 0; hold = 0;
    m_reset();
    @(negedge clk);
    do_reset();
    idle(2);

    // Single frame
    start_scn();
    cyc(1, 32'h12345678, 32'h9ABCDEF0, 0);
    idle(20);
    chk_frames("single", 64'h123456789ABCDEF0, 64'h0, 1);
    if (got_cyc.size() > 0) chk("single_first", 64'(got_cyc[0]), 64'd1);
    chk("single_busy_end", 64'(busy), 64'd0);

    // Hold on stream cycles 3 and 10
    start_scn();
    cyc(1, 32'h12345678, 32'h9ABCDEF0, 0);
    for (int k = 1; k < 22; k++) cyc(0, 32'h0, 32'h0, (k == 3 || k == 10));
    chk_frames("hold", 64'h123456789ABCDEF0, 64'h0, 1);
    if (got_cyc.size() > 0) chk("hold_last", 64'(got_cyc[got_cyc.size()-1]), 64'd18);

    // Back-to-back
    start_scn();
    cyc(1, 32'h12345678, 32'h9ABCDEF0, 0);
    for (int k = 1; k < 42; k++) cyc(k == 5, 32'hFFFFFFFF, 32'h0, 0);
    chk_frames("b2b", 64'h123456789ABCDEF0, 64'hFFFFFFFF00000000, 2);
    if (got_cyc.size() > 16) chk("b2b_second", 64'(got_cyc[16]), 64'd18);
    chk("b2b_ovf", 64'(ovf), 64'd0);

    // Overflow: A, B, C inside one frame
    start_scn();
    cyc(1, 32'hAAAA0001, 32'hAAAA0002, 0);
    for (int k = 1; k < 45; k++)
      cyc(k == 3 || k == 6, (k == 3) ? 32'hBBBB0001 : 32'hCCCC0001,
          (k == 3) ? 32'hBBBB0002 : 32'hCCCC0002, 0);
    chk_frames("ovf", 64'hAAAA0001AAAA0002, 64'hBBBB0001BBBB0002, 2);
    chk("ovf_set", 64'(ovf), 64'd1);
    idle(5);
    chk("ovf_sticky", 64'(ovf), 64'd1);
    do_reset();

    // Result in GAP cycle with pending full
    start_scn();
    cyc(1, 32'h11111111, 32'h22222222, 0);
    for (int k = 1; k < 60; k++)
      cyc(k == 2 || k == 17, (k == 2) ? 32'h33333333 : 32'h55555555,
          (k == 2) ? 32'h44444444 : 32'h66666666, 0);
    chk("gap_count", 64'(got_q.size()), 64'd48);
    if (got_q.size() >= 48) chk("gap_third", 64'(got_q[32]), 64'h5);
    chk("gap_ovf", 64'(ovf), 64'd0);

    // Reset mid-frame
    start_scn();
    cyc(1, 32'h12345678, 32'h9ABCDEF0, 0);
    idle(5);
    chk("mid_kP6", 64'(kP), 64'h6);
    do_reset();
    start_scn();
    cyc(1, 32'hA5C3E1F0, 32'h0F1E2D3C, 0);
    idle(20);
    chk_frames("after_rst", 64'hA5C3E1F00F1E2D3C, 64'h0, 1);

    // Random traffic
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 11) == 0, $urandom, $urandom, $urandom_range(0, 4) == 0);
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
